seq_adder32: RTL
================

SEQ_ADDER32 -- requirements
Module: seq_adder32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, >=4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only when FSM is IDLE or DONE.
REQ-005 SHALL have port sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port busy  output  1  high while FSM is in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have port sum  output  WIDTH  result; held from done until next accepted start.
REQ-011 SHALL have port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-012 SHALL have port ovf  output  1  signed two's-complement overflow.
REQ-013 SHALL have port zero  output  1  high when sum == 0.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE/DONE + start=1: latch a, b XOR {WIDTH{sub}}, carry register <= sub, slice counter <= 0, sum register <= 0; next state RUN.
REQ-016 DONE + start=0: next state IDLE; IDLE + start=0: stay IDLE.
REQ-017 RUN: each cycle add the 2 LSBs of both operand shift registers plus carry register via one 2-bit slice; shift slice sum into sum register from the top (right-shift by 2), right-shift both operand registers by 2, update carry register with slice carry-out, counter += 1.
REQ-018 RUN: exactly WIDTH/2 cycles; at counter == WIDTH/2-1 the next state is DONE.
REQ-019 Latency: start sampled at edge N; busy high after edges N..N+WIDTH/2-1; done high for exactly the one cycle after edge N+WIDTH/2.
REQ-020 On entering DONE: cout <= final carry register; ovf <= (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), with B' the possibly-inverted operand; zero <= (sum == 0).
REQ-021 start while in RUN SHALL be ignored; no queueing; in-flight operation unaffected.
REQ-022 start in DONE SHALL be accepted (back-to-back); done falls, busy rises at the same edge.
REQ-023 a, b, sub changing during RUN SHALL NOT affect the result.
REQ-024 sum, cout, ovf, zero SHALL be stable from the done cycle until the edge accepting the next start, at which point sum clears to 0.
REQ-025 Arithmetic modulo 2^WIDTH; no saturation.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, zero=0, counter=0, carry=0, operand registers 0.
REQ-027 rst asserted mid-RUN SHALL abort the operation; no done pulse is produced for it.
REQ-028 First start SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-029 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH SHALL live in the shared ALU definitions package/include.
REQ-030 SHALL instantiate exactly one existing bit2_adder as the per-cycle slice; no other arithmetic sub-modules.
REQ-031 Counter width SHALL be clog2(WIDTH/2) bits.

Verification
REQ-032 a=0x00000005, b=0x00000003, sub=0 -> done 16 cycles after start; sum=0x00000008, cout=0, ovf=0, zero=0.
REQ-033 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1, cout=0; a=0xFFFFFFFF, b=1 -> sum=0, cout=1, zero=1, ovf=0.
REQ-034 a=0x00000003, b=0x00000005, sub=1 -> sum=0xFFFFFFFE, cout=0; a=b=0x12345678, sub=1 -> sum=0, zero=1, cout=1.
REQ-035 start pulsed again at cycles 3 and 10 of a run, with a,b changed -> ignored; original result returned on schedule.
REQ-036 start held high continuously -> back-to-back ops, done every 17 cycles, busy low only during done cycles.
REQ-037 rst asserted at cycle 8 of RUN -> all outputs 0 asynchronously, no done; next start completes normally.

Source files
------------

// File: rtl/seq_adder32_pkg.sv
// Shared ALU definitions: default operand width, FSM encodings and the
// signed-overflow helper used when a sequential add/sub completes.
package seq_adder32_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: operands agree in sign, result disagrees.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/seq_adder32_bit2_adder.sv
// Two-bit ripple slice: s/cout = a + b + cin. This is the only arithmetic
// element of the sequential adder; it is reused every RUN cycle.
module bit2_adder
    import seq_adder32_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout
);

    logic [2:0] total_s;

    assign total_s = {1'b0, a} + {1'b0, b} + {2'b00, cin};
    assign s       = total_s[1:0];
    assign cout    = total_s[2];

endmodule

// File: rtl/seq_adder32.sv
// Sequential WIDTH-bit adder/subtractor. Subtraction is a + ~b + 1, so the
// operand B is inverted and the carry seeded with 1 when sub is sampled.
// Two result bits are produced per RUN cycle and shifted into the top of sum.
module seq_adder32
    import seq_adder32_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int                CNT_W    = $clog2(WIDTH / 2);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH / 2 - 1);

    state_t             state_r;
    state_t             next_s;
    logic               accept_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   sum_r;
    logic               a_msb_r;
    logic               b_msb_r;
    logic               busy_r;
    logic               done_r;
    logic               cout_r;
    logic               ovf_r;
    logic               zero_r;
    logic [1:0]         slice_sum_s;
    logic               slice_cout_s;
    logic [WIDTH-1:0]   sum_next_s;

    bit2_adder u_slice (
        .a    (a_r[1:0]),
        .b    (b_r[1:0]),
        .cin  (carry_r),
        .s    (slice_sum_s),
        .cout (slice_cout_s)
    );

    // Result after this cycle's slice lands in the top two bits.
    assign sum_next_s = {slice_sum_s, sum_r[WIDTH-1:2]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; a new request is only taken in IDLE or DONE.
    always_comb begin
        next_s   = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s   = RUN;
                    accept_s = 1'b1;
                end else begin
                    next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    next_s = DONE;
                end else begin
                    next_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    next_s   = RUN;
                    accept_s = 1'b1;
                end else begin
                    next_s = IDLE;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, per-cycle slice accumulation, final flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            busy_r <= (next_s == RUN);
            done_r <= (next_s == DONE);
            if (accept_s) begin
                a_r     <= a;
                b_r     <= b ^ {WIDTH{sub}};
                carry_r <= sub;
                cnt_r   <= '0;
                sum_r   <= '0;
                // MSBs are shifted out during RUN, so keep them for overflow.
                a_msb_r <= a[WIDTH-1];
                b_msb_r <= b[WIDTH-1] ^ sub;
            end else if (state_r == RUN) begin
                sum_r   <= sum_next_s;
                a_r     <= a_r >> 2;
                b_r     <= b_r >> 2;
                carry_r <= slice_cout_s;
                cnt_r   <= cnt_r + CNT_W'(1);
                if (cnt_r == LAST_CNT) begin
                    cout_r <= slice_cout_s;
                    ovf_r  <= signed_ovf(a_msb_r, b_msb_r, sum_next_s[WIDTH-1]);
                    zero_r <= (sum_next_s == '0);
                end
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign zero = zero_r;

endmodule
